// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole engine.
// State encoding, LFSR feedback taps and the default seed.
package mole_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        SHOW = 2'd2,
        DONE = 2'd3
    } state_t;

    // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

endpackage

// File: rtl/mole_lfsr.sv
// 16-bit Fibonacci LFSR, free-running every cycle.
// Supplies the pseudo-random mole positions.
module mole_lfsr
    import mole_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else begin
            state <= {state[14:0], ^(state & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/mole_engine.sv
// Whack-a-mole game engine: switch edge detect, mole timer,
// score/miss counters and the game FSM. All outputs are registered.
module mole_engine
    import mole_pkg::*;
#(
    parameter int          N_HOLES      = 16,
    parameter int          SCORE_W      = 6,
    parameter int          TARGET_SCORE = 60,
    parameter int          MAX_MISSES   = 3,
    parameter int          TIMEOUT_CYC  = 100_000_000,
    parameter logic [15:0] LFSR_SEED    = LFSR_SEED_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [N_HOLES-1:0]               sw,
    output logic [N_HOLES-1:0]               led,
    output logic [SCORE_W-1:0]               score,
    output logic [$clog2(MAX_MISSES+1)-1:0]  misses,
    output logic                             playing,
    output logic                             game_over,
    output logic                             win
);

    localparam int IDX_W  = $clog2(N_HOLES);
    localparam int MISS_W = $clog2(MAX_MISSES + 1);
    localparam int TMR_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [SCORE_W-1:0] SCORE_TGT = SCORE_W'(TARGET_SCORE);
    localparam logic [MISS_W-1:0]  MISS_MAX  = MISS_W'(MAX_MISSES);

    function automatic logic [N_HOLES-1:0] onehot(input logic [IDX_W-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    // Mole lifetime halves every 16 points, capped at a quarter.
    function automatic logic [TMR_W-1:0] reload(input logic [SCORE_W-1:0] s);
        int lvl;
        lvl = int'(s) / 16;
        if (lvl > 2) lvl = 2;
        return TMR_W'(TIMEOUT_CYC >> lvl);
    endfunction

    logic [15:0] lfsr;
    logic        unused_lfsr;

    mole_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr)
    );

    assign unused_lfsr = ^lfsr[15:IDX_W];

    state_t              state;
    state_t              state_nx;
    logic [N_HOLES-1:0]  sw_q;
    logic [N_HOLES-1:0]  rise;
    logic [N_HOLES-1:0]  target;
    logic [N_HOLES-1:0]  led_nx;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_nx;
    logic [IDX_W-1:0]    cand;
    logic [IDX_W-1:0]    pick;
    logic [TMR_W-1:0]    timer;
    logic [TMR_W-1:0]    timer_nx;
    logic [SCORE_W-1:0]  score_nx;
    logic [MISS_W-1:0]   misses_nx;
    logic                win_nx;
    logic                expired;
    logic                hit;
    logic                miss;

    always_comb begin
        rise    = sw & ~sw_q;
        target  = onehot(idx);
        cand    = lfsr[IDX_W-1:0];
        pick    = (cand == idx) ? cand + IDX_W'(1) : cand;
        expired = (timer <= TMR_W'(1));
        // Any stray edge is a miss, even alongside the target edge.
        hit     = ((rise & ~target) == '0) && (rise != '0);
        miss    = ((rise & ~target) != '0) || ((rise == '0) && expired);

        state_nx  = state;
        idx_nx    = idx;
        timer_nx  = timer;
        score_nx  = score;
        misses_nx = misses;
        win_nx    = win;

        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx  = ARM;
                    score_nx  = '0;
                    misses_nx = '0;
                    win_nx    = 1'b0;
                end
            end
            ARM: begin
                if (sw == '0) begin
                    state_nx = SHOW;
                    idx_nx   = pick;
                    timer_nx = reload(score);
                end
            end
            SHOW: begin
                if (hit) begin
                    score_nx = score + SCORE_W'(1);
                    if (score_nx == SCORE_TGT) begin
                        state_nx = DONE;
                        win_nx   = 1'b1;
                    end
                end else if (miss) begin
                    misses_nx = misses + MISS_W'(1);
                    if (misses_nx == MISS_MAX) state_nx = DONE;
                end else begin
                    timer_nx = timer - TMR_W'(1);
                end
                if ((hit || miss) && state_nx == SHOW) begin
                    idx_nx   = pick;
                    timer_nx = reload(score_nx);
                end
            end
        endcase

        led_nx = '0;
        if (state_nx == SHOW) begin
            led_nx = onehot(idx_nx);
        end else if (state_nx == DONE && win_nx) begin
            led_nx = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sw_q      <= '0;
            idx       <= '0;
            timer     <= '0;
            led       <= '0;
            score     <= '0;
            misses    <= '0;
            playing   <= 1'b0;
            game_over <= 1'b0;
            win       <= 1'b0;
        end else begin
            state     <= state_nx;
            sw_q      <= sw;
            idx       <= idx_nx;
            timer     <= timer_nx;
            led       <= led_nx;
            score     <= score_nx;
            misses    <= misses_nx;
            playing   <= (state_nx == ARM) || (state_nx == SHOW);
            game_over <= (state_nx == DONE);
            win       <= win_nx;
        end
    end

endmodule

// File: tb/tb_mole_engine.sv
// Bench for mole_engine: directed scenarios plus random play,
// all checked against a behavioural game model every cycle.
module tb_mole_engine;

    localparam int N    = 4;
    localparam int TO   = 8;
    localparam int TGT  = 3;
    localparam int MAXM = 2;

    localparam int P_IDLE = 0;
    localparam int P_ARM  = 1;
    localparam int P_SHOW = 2;
    localparam int P_DONE = 3;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic [3:0] sw    = '0;
    logic [3:0] led;
    logic [5:0] score;
    logic [1:0] misses;
    logic       playing;
    logic       game_over;
    logic       win;

    int total = 0;
    int bad   = 0;

    int m_phase, m_score, m_miss, m_win, m_idx, m_left, m_swq, m_lfsr;
    int seq[$];

    mole_engine #(
        .N_HOLES      (N),
        .SCORE_W      (6),
        .TARGET_SCORE (TGT),
        .MAX_MISSES   (MAXM),
        .TIMEOUT_CYC  (TO),
        .LFSR_SEED    (16'hACE1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sw        (sw),
        .led       (led),
        .score     (score),
        .misses    (misses),
        .playing   (playing),
        .game_over (game_over),
        .win       (win)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 25)
                $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_led();
        if (m_phase == P_SHOW) return 1 << m_idx;
        if (m_phase == P_DONE && m_win != 0) return 15;
        return 0;
    endfunction

    task automatic place_mole();
        int c, lvl;
        c = m_lfsr % N;
        if (c == m_idx) c = (c + 1) % N;
        m_idx = c;
        lvl = m_score / 16;
        if (lvl > 2) lvl = 2;
        m_left = TO >> lvl;
    endtask

    task automatic model_step();
        int rise, other, fb;
        bit expired;
        if (rst) begin
            m_phase = P_IDLE; m_score = 0; m_miss = 0; m_win = 0;
            m_idx = 0; m_left = 0; m_swq = 0; m_lfsr = 16'hACE1;
            return;
        end
        rise = int'(sw) & ~m_swq & 15;
        case (m_phase)
            P_IDLE, P_DONE: if (start) begin
                m_phase = P_ARM; m_score = 0; m_miss = 0; m_win = 0;
            end
            P_ARM: if (sw == 0) begin
                m_phase = P_SHOW;
                place_mole();
            end
            default: begin
                other = rise & ~(1 << m_idx);
                m_left--;
                expired = (m_left == 0);
                if (other != 0 || (rise == 0 && expired)) begin
                    m_miss++;
                    if (m_miss == MAXM) m_phase = P_DONE;
                    else place_mole();
                end else if (rise != 0) begin
                    m_score++;
                    if (m_score == TGT) begin
                        m_phase = P_DONE; m_win = 1;
                    end else begin
                        place_mole();
                    end
                end
            end
        endcase
        m_swq = int'(sw);
        fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
        m_lfsr = ((m_lfsr << 1) | fb) & 16'hFFFF;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            chk("led",       led,       exp_led());
            chk("score",     score,     m_score);
            chk("misses",    misses,    m_miss);
            chk("playing",   playing,   (m_phase == P_ARM || m_phase == P_SHOW) ? 1 : 0);
            chk("game_over", game_over, (m_phase == P_DONE) ? 1 : 0);
            chk("win",       win,       m_win);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got still running want finished");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_phase(input int p, input string nm);
        int k;
        k = 0;
        while (m_phase != p && k < 40) begin
            tick(1);
            k++;
        end
        if (m_phase != p) begin
            total++;
            bad++;
            $display("FAIL %s: got phase %0d want %0d (timeout)", nm, m_phase, p);
        end
    endtask

    task automatic do_hit();
        wait_phase(P_SHOW, "hit_wait");
        sw = 4'(exp_led());
        tick(1);
        sw = '0;
        tick(1);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_led"},  led,       0);
        chk({nm, "_scr"},  score,     0);
        chk({nm, "_mis"},  misses,    0);
        chk({nm, "_ply"},  playing,   0);
        chk({nm, "_go"},   game_over, 0);
        chk({nm, "_win"},  win,       0);
    endtask

    initial begin
        int r;

        // Reset state and the first LFSR step of the model.
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        chk_zero("reset");
        chk("lfsr_pin", m_lfsr, 32'h59C3);

        // Run 1: two hits, record moles, then reset mid-game.
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            wait_phase(P_SHOW, "run1");
            seq.push_back(exp_led());
            do_hit();
        end
        seq.push_back(exp_led());
        chk("run1_score", score, 2);
        rst = 1'b1;
        tick(1);
        chk_zero("midrst");
        tick(1);
        rst = 1'b0;
        tick(1);

        // Run 2: same timing from reset gives the same moles.
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            wait_phase(P_SHOW, "run2");
            chk("mole_seq", led, seq[i]);
            do_hit();
        end
        chk("win_score", score, 3);
        chk("win_go",    game_over, 1);
        chk("win_flag",  win, 1);
        chk("win_led",   led, 4'b1111);

        // Restart from DONE, no input: misses after 8 and 16 cycles.
        pulse_start();
        tick(8);
        chk("to_before", misses, 0);
        tick(1);
        chk("to_first", misses, 1);
        tick(8);
        chk("to_misses", misses, 2);
        chk("to_go",     game_over, 1);
        chk("to_win",    win, 0);
        chk("to_led",    led, 0);

        // Target plus neighbour rising together is a miss.
        pulse_start();
        wait_phase(P_SHOW, "dual");
        r = exp_led();
        sw = 4'(r | (((r << 1) | (r >> 3)) & 15));
        tick(1);
        sw = '0;
        chk("dual_mis",  misses, 1);
        chk("dual_scr",  score, 0);
        chk("dual_move", (led != 4'(r)) ? 1 : 0, 1);
        tick(1);

        // Hit on the very cycle the timer expires counts as a hit.
        begin
            int k;
            k = 0;
            while (!(m_phase == P_SHOW && m_left == 1) && k < 40) begin
                tick(1);
                k++;
            end
        end
        sw = 4'(exp_led());
        tick(1);
        sw = '0;
        chk("race_scr", score, 1);
        chk("race_mis", misses, 1);
        tick(1);

        // Switch held at start keeps ARM and is not a hit.
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        sw = 4'b0100;
        pulse_start();
        tick(4);
        chk("hold_ply", playing, 1);
        chk("hold_led", led, 0);
        sw = '0;
        tick(3);
        chk("hold_show", (led != 0) ? 1 : 0, 1);
        chk("hold_scr", score, 0);

        // Random play, restarts and resets.
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4) sw = '0;
            else if (r < 6) sw = 4'(exp_led());
            else if (r == 6) sw = 4'($urandom_range(0, 15));
            start = ($urandom_range(0, 25) == 0);
            rst   = ($urandom_range(0, 300) == 0);
            tick(1);
        end
        rst   = 1'b0;
        start = 1'b0;
        sw    = '0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mole_engine.md
MOLE_ENGINE -- requirements
Module: mole_engine

Interface
REQ-001 Parameter N_HOLES, default 16, number of holes (switch/LED pairs); SHALL be a power of two, range 4..16.
REQ-002 Parameter SCORE_W, default 6, score counter width.
REQ-003 Parameter TARGET_SCORE, default 60, score that ends the game as a win; SHALL be at most 2^SCORE_W-1.
REQ-004 Parameter MAX_MISSES, default 3, miss count that ends the game as a loss.
REQ-005 Parameter TIMEOUT_CYC, default 100_000_000, base mole lifetime in clk cycles.
REQ-006 Parameter LFSR_SEED, default 16'hACE1, non-zero LFSR reset value.
REQ-007 Ports (clock and reset first):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle pulse; begins or restarts a game
- sw  in  N_HOLES  player switches, already synchronised and debounced upstream
- led  out  N_HOLES  one-hot mole position; all ones on win
- score  out  SCORE_W  hits this game
- misses  out  clog2(MAX_MISSES+1)  misses this game
- playing  out  1  high in ARM/SHOW
- game_over  out  1  high in DONE
- win  out  1  valid while game_over is high

Function
REQ-008 FSM states SHALL be IDLE, ARM, SHOW and DONE.
REQ-009 IDLE: all outputs zero; start -> ARM, with score and misses cleared.
REQ-010 ARM: led zero; stays in ARM until sw == 0. Then -> SHOW, with a new mole chosen and the timer loaded in the same cycle.
REQ-011 Rising edges SHALL be computed as sw & ~sw_q, where sw_q is sw registered once per cycle.
REQ-012 Mole index SHALL be lfsr[log2(N_HOLES)-1:0]; if it equals the previous index, (index+1) mod N_HOLES SHALL be used instead.
REQ-013 The 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) SHALL advance every cycle, independent of state.
REQ-014 SHOW: led = one-hot(index).
- A rising edge on the target only: hit, score+1.
- A rising edge on any non-target switch: miss, misses+1; this holds even if the target also rises in the same cycle.
- Timer reaching zero with no edge: miss.
REQ-015 A hit and a timeout in the same cycle SHALL count as a hit.
REQ-016 After each hit or miss that does not end the game, the new mole and timer reload SHALL take effect on the following cycle (one-cycle latency from the sw edge to the led change). The FSM SHALL remain in SHOW.
REQ-017 Timer reload value SHALL be TIMEOUT_CYC >> level, with level = min(score / 16, 2).
REQ-018 score reaching TARGET_SCORE SHALL cause -> DONE with win=1. misses reaching MAX_MISSES SHALL cause -> DONE with win=0. score and misses SHALL never exceed these limits.
REQ-019 DONE: led all ones if win, else all zero; score, misses and win are held.
REQ-020 A start pulse in DONE SHALL cause -> ARM with counters cleared. A start pulse in ARM or SHOW SHALL be ignored.
REQ-021 All outputs SHALL be registered.

Reset
REQ-022 rst SHALL force IDLE, lfsr = LFSR_SEED, sw_q = 0, timer = 0, and every output to zero, in any state including mid-game.
REQ-023 No output SHALL glitch or carry stale values in the first cycle after reset is released.

Structure
REQ-024 Package mole_pkg SHALL hold the state enum, the LFSR polynomial taps and the default seed.
REQ-025 The LFSR SHALL be a separate sub-module, mole_lfsr, with inputs clk and rst, parameter SEED, and a 16-bit state output.
REQ-026 The timer, edge detect, counters and FSM SHALL reside in mole_engine.

Verification
Bench parameters: N_HOLES=4, TIMEOUT_CYC=8, TARGET_SCORE=3, MAX_MISSES=2.
REQ-027 start, then sw=0, then a target-switch rising edge 3 times -> score 1, 2, 3; game_over=1, win=1, led=4'b1111.
REQ-028 start, then no input -> a miss after 8 cycles and another after 8 more; misses=2, game_over=1, win=0, led=0.
REQ-029 In SHOW with led=0001, drive sw=0011 in one cycle -> misses+1, score unchanged, new mole on the next cycle.
REQ-030 Target edge in the same cycle the timer expires -> score+1, misses unchanged.
REQ-031 start while sw=0100 held -> stays in ARM with led=0 until sw=0, then SHOW; the held switch SHALL NOT count as a hit.
REQ-032 rst asserted in SHOW with score=2 -> next cycle IDLE with all outputs 0. Repeat the start sequence -> the same mole sequence as the first run (seed determinism).
